// File: rtl/fp16_adder_arbiter.sv
// Round-robin arbiter sharing one two-state FP16 adder among NUM_REQ requesters.
// Operands are registered on a ph=1 accept edge and held. The requester tag rides a two-slot pipe
// aligned to the adder phase. {tag, sum} lands in an in-order response FIFO three clocks after accept.
module fp16_adder_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned RSP_DEPTH = 2,
    localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [16*NUM_REQ-1:0] req_a,
    input  logic [16*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    input  logic [15:0]           add_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [15:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  idle
);

    localparam int unsigned DW    = 16;
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 2;

    logic                ph_q, ph_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DW-1:0]       add_a_q, add_a_d;
    logic [DW-1:0]       add_b_q, add_b_d;
    logic                s1_v_q, s1_v_d;
    logic [ID_W-1:0]     s1_tag_q, s1_tag_d;
    logic                s2_v_q, s2_v_d;
    logic [ID_W-1:0]     s2_tag_q, s2_tag_d;
    logic [DW-1:0]       fdata_q [RSP_DEPTH];
    logic [DW-1:0]       fdata_d [RSP_DEPTH];
    logic [ID_W-1:0]     fid_q [RSP_DEPTH];
    logic [ID_W-1:0]     fid_d [RSP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]       rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                idle_q, idle_d;

    logic                pop_c;
    logic                push_c;
    logic                credit_c;
    logic                grant_vld_c;
    logic [ID_W-1:0]     grant_idx_c;
    logic [OCC_W-1:0]    occ_c;
    logic                accept_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit check and round-robin pick of the first valid requester after rr_ptr
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        pop_c       = rsp_valid_q & rsp_ready;
        occ_c       = OCC_W'(s1_v_q) + OCC_W'(s2_v_q) + OCC_W'(cnt_q);
        credit_c    = (occ_c - OCC_W'(pop_c)) < OCC_W'(RSP_DEPTH);
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_vld_c && req_valid[cand]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = cand;
            end
        end
        req_ready = '0;
        if (!rst && ph_q && credit_c && grant_vld_c) begin
            req_ready = NUM_REQ'(1) << grant_idx_c;
        end
        accept_c = |req_ready;
    end

    // Next state: phase, operand hold, tag pipe, response FIFO and status
    always_comb begin
        ph_d        = ~ph_q;
        rr_ptr_d    = rr_ptr_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        s1_v_d      = s1_v_q;
        s1_tag_d    = s1_tag_q;
        s2_v_d      = s2_v_q;
        s2_tag_d    = s2_tag_q;
        fdata_d     = fdata_q;
        fid_d       = fid_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        push_c      = 1'b0;

        if (ph_q) begin
            // adder is writing the result of the op in s1; that op moves to s2
            s2_v_d   = s1_v_q;
            s2_tag_d = s1_tag_q;
            s1_v_d   = 1'b0;
            if (accept_c) begin
                s1_v_d   = 1'b1;
                s1_tag_d = grant_idx_c;
                rr_ptr_d = grant_idx_c;
                add_a_d  = req_a[32'(grant_idx_c) * DW +: DW];
                add_b_d  = req_b[32'(grant_idx_c) * DW +: DW];
            end
        end else begin
            // add_result now holds the sum for the op in s2
            push_c = s2_v_q;
            s2_v_d = 1'b0;
        end

        if (push_c) begin
            fdata_d[wr_ptr_q] = add_result;
            fid_d[wr_ptr_q]   = s2_tag_q;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        if (pop_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);

        rsp_valid_d = (cnt_d != '0);
        rsp_data_d  = fdata_d[rd_ptr_d];
        rsp_id_d    = fid_d[rd_ptr_d];
        idle_d      = !(s1_v_d || s2_v_d) && (cnt_d == '0);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_q        <= 1'b0;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            add_a_q     <= '0;
            add_b_q     <= '0;
            s1_v_q      <= 1'b0;
            s1_tag_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_tag_q    <= '0;
            for (int unsigned i = 0; i < RSP_DEPTH; i++) begin
                fdata_q[i] <= '0;
                fid_q[i]   <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            idle_q      <= 1'b1;
        end else begin
            ph_q        <= ph_d;
            rr_ptr_q    <= rr_ptr_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            s1_v_q      <= s1_v_d;
            s1_tag_q    <= s1_tag_d;
            s2_v_q      <= s2_v_d;
            s2_tag_q    <= s2_tag_d;
            fdata_q     <= fdata_d;
            fid_q       <= fid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            idle_q      <= idle_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign idle      = idle_q;

endmodule

// File: tb/tb_fp16_adder_arbiter.sv
// Directed bench for fp16_adder_arbiter with a behavioural two-state FP16 adder attached.
module tb_fp16_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_ready;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic [15:0] add_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        idle;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        tb_ph;

    fp16_adder_arbiter #(.NUM_REQ(4), .RSP_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .idle(idle)
    );

    always #5 clk = ~clk;

    // Reference FP16 add, round to nearest even; finite inputs assumed
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        int unsigned ea, eb, e, d, grs, m, ma, mb, t;
        logic sa, sb, ts;
        sa = a[15]; ea = 32'(a[14:10]); ma = 32'(a[9:0]);
        sb = b[15]; eb = 32'(b[14:10]); mb = 32'(b[9:0]);
        if (ea == 0) ea = 1; else ma = ma | 32'd1024;
        if (eb == 0) eb = 1; else mb = mb | 32'd1024;
        ma = ma << 3; mb = mb << 3;
        if (ea < eb || (ea == eb && ma < mb)) begin
            t = ea; ea = eb; eb = t;
            t = ma; ma = mb; mb = t;
            ts = sa; sa = sb; sb = ts;
        end
        d = ea - eb;
        if (d > 14) mb = (mb != 0) ? 32'd1 : 32'd0;
        else mb = (mb >> d) | (((mb & ((32'd1 << d) - 1)) != 0) ? 32'd1 : 32'd0);
        e = ea;
        m = (sa == sb) ? ma + mb : ma - mb;
        if (m == 0) return 16'h0000;
        if (m >= (32'd2048 << 3)) begin
            m = (m >> 1) | (m & 32'd1);
            e = e + 1;
        end
        while (m < (32'd1024 << 3) && e > 1) begin
            m = m << 1;
            e = e - 1;
        end
        grs = m & 32'd7;
        m = m >> 3;
        if (grs > 4 || (grs == 4 && m[0])) m = m + 1;
        if (m == 32'd2048) begin
            m = m >> 1;
            e = e + 1;
        end
        if (e >= 31) return {sa, 5'h1f, 10'h000};
        if (m < 32'd1024) e = 0;
        return {sa, e[4:0], m[9:0]};
    endfunction

    // Shared adder: state 0 samples operands, state 1 writes the sum
    logic        ad_st;
    logic [15:0] ad_sa, ad_sb;
    always @(posedge clk) begin
        if (rst) begin
            ad_st      <= 1'b0;
            ad_sa      <= 16'h0;
            ad_sb      <= 16'h0;
            add_result <= 16'h0;
        end else begin
            ad_st <= ~ad_st;
            if (!ad_st) begin
                ad_sa <= add_a;
                ad_sb <= add_b;
            end else begin
                add_result <= fp16_add(ad_sa, ad_sb);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        tb_ph = ~tb_ph;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tb_ph = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b);
        req_a[16*r +: 16] = a;
        req_b[16*r +: 16] = b;
    endtask

    int exp_id [6] = '{0, 2, 0, 2, 0, 2};
    logic [15:0] exp_dat;
    logic [15:0] ra, rb;

    initial begin
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; tb_ph = 1'b0;
        do_reset();

        // reset state
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_add_a", 32'(add_a), 32'h0);
        chk("rst_add_b", 32'(add_b), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_idle", 32'(idle), 32'h1);

        // 1) single op 1.0 + 2.0
        set_req(0, 16'h3C00, 16'h4000);
        req_valid = 4'b0001;
        #1 chk("t1_ready_ph0", 32'(req_ready), 32'h0);
        cyc();
        chk("t1_ready_ph1", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        chk("t1_add_a", 32'(add_a), 32'h3C00);
        chk("t1_add_b", 32'(add_b), 32'h4000);
        chk("t1_idle_busy", 32'(idle), 32'h0);
        cyc();
        cyc();
        chk("t1_rsp_early", 32'(rsp_valid), 32'h0);
        chk("t1_add_a_hold", 32'(add_a), 32'h3C00);
        cyc();
        chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t1_rsp_data", 32'(rsp_data), 32'h4200);
        chk("t1_rsp_id", 32'(rsp_id), 32'h0);
        rsp_ready = 1'b1;
        cyc();
        chk("t1_popped", 32'(rsp_valid), 32'h0);
        chk("t1_idle", 32'(idle), 32'h1);

        // 2) req0 and req2 continuously valid: grants alternate, responses in order
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 16'h3C00, 16'h3C00);
        set_req(2, 16'h4000, 16'h4000);
        req_valid = 4'b0101;
        cyc();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t2_grant%0d", k), 32'(req_ready), 32'(4'b0001 << exp_id[k]));
            if (k >= 2) begin
                exp_dat = (exp_id[k-2] == 0) ? 16'h4000 : 16'h4400;
                chk($sformatf("t2_rsp_valid%0d", k), 32'(rsp_valid), 32'h1);
                chk($sformatf("t2_rsp_id%0d", k), 32'(rsp_id), 32'(exp_id[k-2]));
                chk($sformatf("t2_rsp_data%0d", k), 32'(rsp_data), 32'(exp_dat));
            end
            cyc();
            cyc();
        end
        req_valid = '0;

        // 3) request raised in a ph=0 cycle waits one clock
        do_reset();
        set_req(1, 16'h4500, 16'hC200);
        req_valid = 4'b0010;
        #1 chk("t3_ready_ph0", 32'(req_ready), 32'h0);
        cyc();
        chk("t3_ready_ph1", 32'(req_ready), 32'h2);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        cyc();
        chk("t3_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("t3_rsp_data", 32'(rsp_data), 32'h4000);
        chk("t3_rsp_id", 32'(rsp_id), 32'h1);

        // 4) back-pressure: only RSP_DEPTH accepts, then resume on release
        do_reset();
        for (int r = 0; r < 4; r++) set_req(r, 16'h3E00, 16'h4100);
        req_valid = 4'b1111;
        cyc();
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t4_ready%0d", k), 32'(req_ready),
                (k == 0) ? 32'h1 : (k == 1) ? 32'h2 : 32'h0);
            cyc();
            cyc();
        end
        chk("t4_full_valid", 32'(rsp_valid), 32'h1);
        rsp_ready = 1'b1;
        #1;
        chk("t4_pop0_data", 32'(rsp_data), 32'h4400);
        chk("t4_pop0_id", 32'(rsp_id), 32'h0);
        chk("t4_resume_grant", 32'(req_ready), 32'h4);
        cyc();
        chk("t4_pop1_valid", 32'(rsp_valid), 32'h1);
        chk("t4_pop1_data", 32'(rsp_data), 32'h4400);
        chk("t4_pop1_id", 32'(rsp_id), 32'h1);
        cyc();
        chk("t4_next_grant", 32'(req_ready), 32'h8);
        req_valid = '0;

        // 5) reset one clock after an accept discards the op
        do_reset();
        set_req(0, 16'h3C00, 16'h3C00);
        req_valid = 4'b0001;
        cyc();
        chk("t5_grant", 32'(req_ready), 32'h1);
        cyc();
        req_valid = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tb_ph = 1'b0;
        rsp_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("t5_no_rsp%0d", k), 32'(rsp_valid), 32'h0);
            chk($sformatf("t5_idle%0d", k), 32'(idle), 32'h1);
            cyc();
        end
        for (int r = 0; r < 4; r++) set_req(r, 16'h3C00, 16'h3C00);
        req_valid = 4'b1111;
        cyc();
        chk("t5_first_grant", 32'(req_ready), 32'h1);
        req_valid = '0;

        // 6) random FP16 pairs across all requesters
        do_reset();
        for (int i = 0; i < 16; i++) begin
            int r;
            r  = i % 4;
            ra = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
            rb = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
            set_req(r, ra, rb);
            req_valid = 4'(1 << r);
            rsp_ready = 1'b0;
            if (!tb_ph) cyc();
            #1 chk($sformatf("t6_grant%0d", i), 32'(req_ready), 32'(1 << r));
            cyc();
            req_valid = '0;
            rsp_ready = 1'b1;
            for (int j = 0; j < 8; j++) begin
                if (rsp_valid) break;
                cyc();
            end
            chk($sformatf("t6_rsp_valid%0d", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("t6_rsp_data%0d", i), 32'(rsp_data), 32'(fp16_add(ra, rb)));
            chk($sformatf("t6_rsp_id%0d", i), 32'(rsp_id), 32'(r));
            cyc();
        end
        chk("t6_idle_end", 32'(idle), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
